// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared bus widths, byte-lane mask constants and
// lane helpers used by the MEM-stage access unit and its load extender.
package mem_access_unit_pkg;

  localparam int DATA_BUS_WIDTH     = 32;
  localparam int ADDR_BUS_WIDTH     = 32;
  localparam int REG_ADDR_BUS_WIDTH = 5;
  localparam int MEM_SEL_BUS_WIDTH  = 4;

  typedef logic [DATA_BUS_WIDTH-1:0]     data_bus_t;
  typedef logic [ADDR_BUS_WIDTH-1:0]     addr_bus_t;
  typedef logic [REG_ADDR_BUS_WIDTH-1:0] reg_addr_bus_t;
  typedef logic [MEM_SEL_BUS_WIDTH-1:0]  mem_sel_bus_t;

  localparam mem_sel_bus_t MEM_SEL_BYTE0 = 4'b0001;
  localparam mem_sel_bus_t MEM_SEL_BYTE1 = 4'b0010;
  localparam mem_sel_bus_t MEM_SEL_BYTE2 = 4'b0100;
  localparam mem_sel_bus_t MEM_SEL_BYTE3 = 4'b1000;
  localparam mem_sel_bus_t MEM_SEL_HALF0 = 4'b0011;
  localparam mem_sel_bus_t MEM_SEL_HALF1 = 4'b1100;
  localparam mem_sel_bus_t MEM_SEL_WORD  = 4'b1111;

  typedef enum logic [1:0] {
    LANE_BYTE,
    LANE_HALF,
    LANE_WORD,
    LANE_RAW
  } lane_kind_e;

  // Classify a lane mask; anything not a clean byte/half/word is RAW.
  function automatic lane_kind_e lane_kind(input mem_sel_bus_t sel);
    case (sel)
      MEM_SEL_BYTE0, MEM_SEL_BYTE1,
      MEM_SEL_BYTE2, MEM_SEL_BYTE3: return LANE_BYTE;
      MEM_SEL_HALF0, MEM_SEL_HALF1: return LANE_HALF;
      MEM_SEL_WORD:                 return LANE_WORD;
      default:                      return LANE_RAW;
    endcase
  endfunction

  // Replicate a right-justified store value across every lane it could
  // land in, so the strobes alone pick the bytes that get written.
  function automatic data_bus_t store_replicate(input mem_sel_bus_t sel, input data_bus_t data);
    case (lane_kind(sel))
      LANE_BYTE: return {4{data[7:0]}};
      LANE_HALF: return {2{data[15:0]}};
      default:   return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-RAM request/ready bus between the MEM stage
// (master) and the data memory (slave).
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic         ram_en;
  mem_sel_bus_t ram_write_en;
  addr_bus_t    ram_addr;
  data_bus_t    ram_write_data;
  logic         ram_ready;
  data_bus_t    ram_read_data;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data,
    input  ram_ready, ram_read_data
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data,
    output ram_ready, ram_read_data
  );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// mem_load_extend: picks the addressed byte/half out of a loaded word and
// sign- or zero-extends it; unusual lane masks return the raw word.
module mem_load_extend
  import mem_access_unit_pkg::*;
(
  input  mem_sel_bus_t mem_sel_i,
  input  logic         sign_i,
  input  data_bus_t    data_i,
  output data_bus_t    data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension to the full register width.
  always_comb begin
    byte_sel = data_i[7:0];
    half_sel = data_i[15:0];
    data_o   = data_i;
    case (mem_sel_i)
      MEM_SEL_BYTE1: byte_sel = data_i[15:8];
      MEM_SEL_BYTE2: byte_sel = data_i[23:16];
      MEM_SEL_BYTE3: byte_sel = data_i[31:24];
      MEM_SEL_HALF1: half_sel = data_i[31:16];
      default: ;
    endcase
    case (lane_kind(mem_sel_i))
      LANE_BYTE: data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      LANE_HALF: data_o = {{16{sign_i & half_sel[15]}}, half_sel};
      default:   data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine. Issues each access exactly
// once, stalls the pipe while the RAM is busy, and parks completed results
// in HOLD while a downstream stall freezes the stage.
// Optional wait-state timeout: define MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_current_stage,
  input  logic              mem_read_flag_in,
  input  logic              mem_write_flag_in,
  input  logic              mem_sign_flag_in,
  input  mem_sel_bus_t      mem_sel_in,
  input  data_bus_t         mem_write_data_in,
  input  data_bus_t         result_in,
  input  logic              reg_write_en_in,
  input  reg_addr_bus_t     reg_write_addr_in,
  input  addr_bus_t         current_pc_addr_in,
  mem_access_unit_if.master ram,
  output data_bus_t         result_out,
  output logic              reg_write_en_out,
  output reg_addr_bus_t     reg_write_addr_out,
  output addr_bus_t         current_pc_addr_out,
  output logic              stall_request,
  output logic              bus_error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("mem_access_unit: TIMEOUT_CYCLES must lie in 1..255");
  end

  logic [1:0] state_q, state_d;
  data_bus_t  hold_data_q, hold_data_d;
  data_bus_t  load_ext;
  logic       mem_op, is_read, access_done, timeout_hit, hold_err;

  // A simultaneous read+write is treated as a plain store.
  assign mem_op  = mem_read_flag_in | mem_write_flag_in;
  assign is_read = mem_read_flag_in & ~mem_write_flag_in;

  assign ram.ram_en         = mem_op & (state_q != ST_HOLD) & ~rst & ~timeout_hit;
  assign ram.ram_write_en   = (mem_write_flag_in & ram.ram_en) ? mem_sel_in : '0;
  assign ram.ram_addr       = {result_in[31:2], 2'b00};
  assign ram.ram_write_data = store_replicate(mem_sel_in, mem_write_data_in);

  assign stall_request = ram.ram_en & ~ram.ram_ready;
  assign access_done   = (ram.ram_en & ram.ram_ready) | timeout_hit;
  assign bus_error     = timeout_hit;

  mem_load_extend u_load_extend (
    .mem_sel_i (mem_sel_in),
    .sign_i    (mem_sign_flag_in),
    .data_i    (ram.ram_read_data),
    .data_o    (load_ext)
  );

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [7:0] timeout_cnt_q, timeout_cnt_d;
  logic       hold_err_q, hold_err_d;

  assign timeout_hit = (state_q == ST_WAIT) & mem_op & ~ram.ram_ready &
                       (timeout_cnt_q == 8'(TIMEOUT_CYCLES));
  assign hold_err    = hold_err_q;

  // Count cycles spent in WAIT; a timed-out result stays squashed in HOLD.
  always_comb begin
    timeout_cnt_d = '0;
    if (state_q == ST_WAIT && state_d == ST_WAIT) begin
      timeout_cnt_d = timeout_cnt_q + 8'd1;
    end
    hold_err_d = (state_d == ST_HOLD) & (timeout_hit | ((state_q == ST_HOLD) & hold_err_q));
  end

  // Timeout counter and squash flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_cnt_q <= '0;
      hold_err_q    <= 1'b0;
    end else begin
      timeout_cnt_q <= timeout_cnt_d;
      hold_err_q    <= hold_err_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign hold_err    = 1'b0;
`endif

  // Access sequencing plus capture of the result when the stage is frozen.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (!mem_op) begin
          state_d = ST_IDLE;
        end else if (access_done) begin
          state_d = stall_current_stage ? ST_HOLD : ST_IDLE;
          if (stall_current_stage) begin
            hold_data_d = timeout_hit ? '0 : (is_read ? load_ext : result_in);
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (!stall_current_stage) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and HOLD latch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
    end
  end

  // WB-bound result: fresh load data, parked data, or the ALU result.
  always_comb begin
    if (state_q == ST_HOLD)                       result_out = hold_data_q;
    else if (timeout_hit)                         result_out = '0;
    else if (is_read & ram.ram_en & ram.ram_ready) result_out = load_ext;
    else                                          result_out = result_in;
  end

  assign reg_write_en_out    = reg_write_en_in & ~timeout_hit & ~hold_err;
  assign reg_write_addr_out  = reg_write_addr_in;
  assign current_pc_addr_out = current_pc_addr_in;

endmodule
